// File: rtl/inst_fetch.sv
// inst_fetch: IDLE/WAIT/COOL fetch FSM feeding a one-entry decode slot; define ICACHE_EN for a 32-entry direct-mapped I-cache.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_or_not,
  input  logic [31:0] jump_addr,
  input  logic        id_stall,
  output logic        if_request,
  output logic [31:0] if_addr,
  input  logic [31:0] if_inst,
  input  logic        if_enable,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);
  typedef enum logic [1:0] {IDLE, WAIT, COOL} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, id_pc_n, id_inst_n, hit_inst;
  logic id_valid_n, slot_free, hit, mem_load, hit_load, load, fill;
  assign if_request = state == WAIT;
  assign if_addr = pc;
  assign fill = rdy && mem_load && !jump_or_not;
`ifdef ICACHE_EN
  logic [31:0] c_data [32];
  logic [24:0] c_tag [32];
  logic [31:0] c_valid;
  assign hit = c_valid[pc[6:2]] && c_tag[pc[6:2]] == pc[31:7];
  assign hit_inst = c_data[pc[6:2]];
  always_ff @(posedge clk or posedge rst)
    if (rst) c_valid <= '0;
    else if (fill) c_valid[pc[6:2]] <= 1'b1;
  always_ff @(posedge clk)
    if (fill) begin
      c_data[pc[6:2]] <= if_inst;
      c_tag[pc[6:2]] <= pc[31:7];
    end
`else
  assign hit = 1'b0;
  assign hit_inst = '0;
`endif
  always_comb begin
    slot_free = !id_valid || !id_stall;
    mem_load = state == WAIT && if_enable;
    hit_load = state == IDLE && slot_free && hit;
    load = !jump_or_not && (mem_load || hit_load);
    state_n = jump_or_not ? IDLE :
              state == IDLE ? ((slot_free && !hit) ? WAIT : IDLE) :
              state == WAIT ? (if_enable ? COOL : WAIT) : IDLE;
    pc_n = jump_or_not ? jump_addr : load ? pc + 32'd4 : pc;
    id_valid_n = load || (id_valid && id_stall && !jump_or_not);
    id_pc_n = load ? pc : id_pc;
    id_inst_n = load ? (mem_load ? if_inst : hit_inst) : id_inst;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      id_valid <= 1'b0;
      id_pc <= '0;
      id_inst <= '0;
    end else if (rdy) begin
      state <= state_n;
      pc <= pc_n;
      id_valid <= id_valid_n;
      id_pc <= id_pc_n;
      id_inst <= id_inst_n;
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed checks of the fetch FSM, stall, redirect and reset behaviour; cache loop when ICACHE_EN is defined.
module tb_inst_fetch;
  logic clk = 0, rst = 1, rdy = 1, jump_or_not = 0, id_stall = 0, if_enable = 0;
  logic [31:0] jump_addr = '0, if_inst = '0;
  logic if_request, id_valid;
  logic [31:0] if_addr, id_pc, id_inst;
  int checks = 0, errors = 0;
  inst_fetch dut (.clk(clk), .rst(rst), .rdy(rdy), .jump_or_not(jump_or_not), .jump_addr(jump_addr),
    .id_stall(id_stall), .if_request(if_request), .if_addr(if_addr), .if_inst(if_inst),
    .if_enable(if_enable), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input logic req, input logic [31:0] addr, input logic v,
                      input logic [31:0] p, input logic [31:0] i);
    chk({tag, ".if_request"}, {31'b0, if_request}, {31'b0, req});
    chk({tag, ".if_addr"}, if_addr, addr);
    chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, v});
    chk({tag, ".id_pc"}, id_pc, p);
    chk({tag, ".id_inst"}, id_inst, i);
  endtask
`ifdef ICACHE_EN
  task automatic mem_fetch(input logic [31:0] a);
    for (int n = 0; n < 10 && !if_request; n++) tick();
    chk("cfetch.req", {31'b0, if_request}, 32'd1);
    chk("cfetch.addr", if_addr, a);
    if_enable = 1;
    if_inst = a + 32'h1000;
    tick();
    if_enable = 0;
    chk("cfetch.id_inst", id_inst, a + 32'h1000);
  endtask
`endif
  initial begin
    #1;
    outs("reset", 0, 0, 0, 0, 0);
    tick();
    rst = 0;
    tick();
    outs("first_req", 1, 0, 0, 0, 0);
    tick();
    tick();
    outs("wait_hold", 1, 0, 0, 0, 0);
    if_enable = 1;
    if_inst = 32'h00000013;
    tick();
    outs("deliver", 0, 4, 1, 0, 32'h13);
    if_enable = 0;
    id_stall = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      outs("stall", 0, 4, 1, 0, 32'h13);
    end
    id_stall = 0;
    tick();
    outs("after_stall", 1, 4, 0, 0, 32'h13);
    if_enable = 1;
    if_inst = 32'hAAAA0001;
    tick();
    outs("held_en1", 0, 8, 1, 4, 32'hAAAA0001);
    tick();
    outs("held_en2_cool", 0, 8, 0, 4, 32'hAAAA0001);
    tick();
    outs("held_en3", 1, 8, 0, 4, 32'hAAAA0001);
    if_inst = 32'hDEADBEEF;
    jump_or_not = 1;
    jump_addr = 32'h100;
    tick();
    outs("jump_drop", 0, 32'h100, 0, 4, 32'hAAAA0001);
    jump_or_not = 0;
    if_enable = 0;
    tick();
    outs("jump_req", 1, 32'h100, 0, 4, 32'hAAAA0001);
    rdy = 0;
    if_enable = 1;
    if_inst = 32'h12345678;
    tick();
    outs("rdy_hold", 1, 32'h100, 0, 4, 32'hAAAA0001);
    rdy = 1;
    tick();
    outs("rdy_load", 0, 32'h104, 1, 32'h100, 32'h12345678);
    if_enable = 0;
    tick();
    tick();
    outs("refetch", 1, 32'h104, 0, 32'h100, 32'h12345678);
    rst = 1;
    #1;
    outs("async_rst", 0, 0, 0, 0, 0);
    if_enable = 1;
    if_inst = 32'h0BAD0BAD;
    tick();
    rst = 0;
    tick();
    outs("late_en", 1, 0, 0, 0, 0);
    if_enable = 0;
    tick();
    outs("post_rst_wait", 1, 0, 0, 0, 0);
`ifdef ICACHE_EN
    rst = 1;
    tick();
    rst = 0;
    for (int a = 0; a < 16; a += 4) mem_fetch(a);
    jump_or_not = 1;
    jump_addr = 0;
    tick();
    jump_or_not = 0;
    for (int a = 0; a < 16; a += 4) begin
      tick();
      outs("hit", 0, a + 4, 1, a, a + 32'h1000);
    end
    tick();
    chk("miss_0x10", {31'b0, if_request}, 32'd1);
    jump_or_not = 1;
    jump_addr = 32'h80;
    tick();
    jump_or_not = 0;
    mem_fetch(32'h80);
    jump_or_not = 1;
    jump_addr = 0;
    tick();
    jump_or_not = 0;
    tick();
    outs("evicted", 1, 0, 0, 32'h80, 32'h1080);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 rdy  input  1  global enable; when 0, all registers hold.
REQ-004 jump_or_not  input  1  redirect request from execute; also routed to the memory controller.
REQ-005 jump_addr  input  32  redirect target PC.
REQ-006 id_stall  input  1  decode cannot accept; holds the output slot.
REQ-007 if_request  output  1  fetch request to memory controller; equals (state==WAIT).
REQ-008 if_addr  output  32  fetch address; equals pc register.
REQ-009 if_inst  input  32  fetched word from memory controller.
REQ-010 if_enable  input  1  if_inst valid; sampled only in WAIT.
REQ-011 id_valid  output  1  output slot holds an instruction.
REQ-012 id_pc  output  32  PC of the slot instruction.
REQ-013 id_inst  output  32  slot instruction.

Function
REQ-014 FSM states IDLE, WAIT, COOL; registered; transitions only when rdy=1.
REQ-015 Slot free = (id_valid==0) or (id_stall==0).
REQ-016 IDLE, slot free, no cache hit: next state WAIT; pc unchanged.
REQ-017 IDLE, slot not free: stay IDLE; no request.
REQ-018 WAIT, if_enable=0: stay WAIT; if_request held at 1; pc stable.
REQ-019 WAIT, if_enable=1: id_inst<=if_inst, id_pc<=pc, id_valid<=1, pc<=pc+4 (mod 2^32), next state COOL.
REQ-020 COOL: if_request=0 for exactly one cycle; if_enable ignored; next state IDLE; ensures a stale if_enable never double-loads.
REQ-021 Slot consumed (id_valid=1, id_stall=0) with no same-cycle load: id_valid<=0.
REQ-022 id_stall=1 with id_valid=1: id_valid, id_pc and id_inst hold.
REQ-023 jump_or_not=1 in any state: pc<=jump_addr, id_valid<=0, next state IDLE; this overrides any same-cycle if_enable, load or cache fill; the in-flight result is discarded.
REQ-024 Fetch latency: first request is asserted one cycle after reset release.
REQ-025 Delivery latency: id_valid rises the edge after if_enable is sampled in WAIT.
REQ-026 No fetch is issued while a stalled instruction occupies the slot.

Reset
REQ-027 On rst: pc=0, state=IDLE, id_valid=0, id_pc=0, id_inst=0, all cache valid bits=0.
REQ-028 rst asserted mid-fetch (WAIT): the request drops immediately (if_request=0) and the pending word is never delivered.

Configuration
REQ-029 Macro ICACHE_EN: when defined, a 32-entry direct-mapped instruction cache is compiled in.
- Index pc[6:2]; tag pc[31:7]; one valid bit per entry.
REQ-030 With ICACHE_EN, hit in IDLE with slot free:
- Load the slot from the cache.
- pc<=pc+4.
- Stay IDLE.
- No memory request.
- One instruction per cycle on consecutive hits.
REQ-031 With ICACHE_EN, the accepted if_enable in WAIT also writes data, tag and valid at index pc[6:2] (overwrite on conflict); no write when jump_or_not=1 in the same cycle.
REQ-032 Without ICACHE_EN: no cache storage; every fetch goes through WAIT; behaviour otherwise identical.

Verification
REQ-033 Reset release, memory returns 0x00000013 three cycles after request:
- if_addr=0 while if_request=1.
- Then id_valid=1, id_pc=0, id_inst=0x00000013.
- pc=4.
- One COOL cycle with if_request=0.
REQ-034 id_stall=1 held 5 cycles with id_valid=1:
- Outputs stable.
- if_request stays 0.
- After release, next fetch at id_pc+4.
REQ-035 jump_or_not=1 with jump_addr=0x100 in the same cycle as if_enable=1:
- id_valid=0 next cycle.
- The word is dropped.
- Next request has if_addr=0x100.
REQ-036 if_enable held high for 3 cycles:
- Exactly one instruction delivered.
- COOL observed.
REQ-037 ICACHE_EN: loop 0x0..0xC executed twice:
- Second pass issues no if_request.
- id_valid=1 on 4 consecutive cycles.
- Fetching 0x80 (index 0) evicts 0x0; refetch of 0x0 goes to memory.
REQ-038 rst pulsed while in WAIT:
- if_request=0 and all outputs zero immediately.
- The late if_enable is ignored.
- Refetch starts at 0.
